// File: rtl/bcd_sseg_scanner.sv
// Latches packed BCD from the binary-to-BCD converter and time-multiplexes it onto a
// 4-digit common-anode seven-segment display with leading-zero blanking and error flag.
module bcd_sseg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] bcd,
    input  logic        bcd_valid,
    input  logic        blank_en,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        dp,
    output logic        err,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        SLOT_ONES = 2'd0,
        SLOT_TENS = 2'd1,
        SLOT_HUND = 2'd2,
        SLOT_IDLE = 2'd3
    } slot_e;

    slot_e            slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q;
    logic [11:0]      disp_q;
    logic [3:0]       an_d;
    logic [6:0]       sseg_d;
    logic             frame_tick_d;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    // Capture register and invalid-digit flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q <= 12'h000;
            err    <= 1'b0;
        end else if (bcd_valid) begin
            disp_q <= bcd;
            err    <= (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
        end
    end

    // Refresh divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              cnt_q <= '0;
        else if (cnt_q == CNT_MAX) cnt_q <= '0;
        else                       cnt_q <= cnt_q + CNT_W'(1);
    end

    // Scan state register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= SLOT_ONES;
            an         <= 4'b1111;
            sseg       <= 7'b1111111;
            frame_tick <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            an         <= an_d;
            sseg       <= sseg_d;
            frame_tick <= frame_tick_d;
        end
    end

    // Next slot and display drive from the current slot and latched value.
    always_comb begin
        logic [3:0] digit;
        logic [3:0] an_sel;
        logic       lit;
        slot_d       = slot_q;
        an_d         = 4'b1111;
        sseg_d       = 7'b1111111;
        frame_tick_d = 1'b0;
        digit        = 4'd0;
        an_sel       = 4'b1111;
        lit          = 1'b0;

        if (cnt_q == CNT_MAX) begin
            case (slot_q)
                SLOT_ONES: slot_d = SLOT_TENS;
                SLOT_TENS: slot_d = SLOT_HUND;
                SLOT_HUND: slot_d = SLOT_IDLE;
                default: begin
                    slot_d       = SLOT_ONES;
                    frame_tick_d = 1'b1;
                end
            endcase
        end

        // Blanking only ever hits zero nibbles, so invalid digits stay visible.
        case (slot_q)
            SLOT_ONES: begin
                digit  = disp_q[3:0];
                an_sel = 4'b1110;
                lit    = 1'b1;
            end
            SLOT_TENS: begin
                digit  = disp_q[7:4];
                an_sel = 4'b1101;
                lit    = !(blank_en && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0));
            end
            SLOT_HUND: begin
                digit  = disp_q[11:8];
                an_sel = 4'b1011;
                lit    = !(blank_en && (disp_q[11:8] == 4'd0));
            end
            default: ;
        endcase

        if (lit) begin
            an_d   = an_sel;
            sseg_d = seg_decode(digit);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_sseg_scanner.sv
// Scoreboard bench for bcd_sseg_scanner: a cycle model pushes the expected output word
// for every edge, and the word is popped and compared once the DUT has registered it.
module tb_bcd_sseg_scanner;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        blank_en;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic        err;
    logic        frame_tick;

    bcd_sseg_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .blank_en   (blank_en),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .err        (err),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       err;
        logic       ft;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ticks;
    exp_t sb_q[$];

    logic [6:0] seg_lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic [11:0] m_disp;
    logic        m_err;
    int          m_cnt;
    int          m_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_disp = 12'h000;
        m_err  = 1'b0;
        m_cnt  = 0;
        m_idx  = 0;
        sb_q.delete();
    endtask

    function automatic exp_t predict();
        exp_t       e;
        logic [3:0] h, t, o;
        h = m_disp[11:8];
        t = m_disp[7:4];
        o = m_disp[3:0];
        e.an   = 4'b1111;
        e.sseg = 7'b1111111;
        case (m_idx)
            0: begin e.an = 4'b1110; e.sseg = seg_lut[o]; end
            1: if (!(blank_en && h == 4'd0 && t == 4'd0)) begin
                   e.an = 4'b1101; e.sseg = seg_lut[t];
               end
            2: if (!(blank_en && h == 4'd0)) begin
                   e.an = 4'b1011; e.sseg = seg_lut[h];
               end
            default: ;
        endcase
        e.err = bcd_valid ? (bcd[11:8] > 9 || bcd[7:4] > 9 || bcd[3:0] > 9) : m_err;
        e.ft  = (m_cnt == DIV - 1) && (m_idx == 3);
        return e;
    endfunction

    // One clock: push expectation, advance model across the edge, pop and compare.
    task automatic cycle();
        exp_t e;
        sb_q.push_back(predict());
        @(posedge clk);
        if (bcd_valid) begin
            m_err  = (bcd[11:8] > 9 || bcd[7:4] > 9 || bcd[3:0] > 9);
            m_disp = bcd;
        end
        if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_cnt++;
        end
        #1;
        e = sb_q.pop_front();
        check("outputs{an,sseg,err,ft}", {19'd0, an, sseg, err, frame_tick}, {19'd0, e});
        check("dp", {31'd0, dp}, 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input logic [11:0] v);
        bcd       = v;
        bcd_valid = 1'b1;
        cycle();
        bcd_valid = 1'b0;
    endtask

    // Advance until the model is at the last count of the requested slot.
    task automatic align(input int idx);
        for (int i = 0; i < 4 * DIV + 1; i++) begin
            if (m_cnt == DIV - 1 && m_idx == idx) break;
            cycle();
        end
        check("align", m_idx, idx);
    endtask

    initial begin
        reset_n   = 1'b0;
        bcd       = 12'h000;
        bcd_valid = 1'b0;
        blank_en  = 1'b0;
        model_reset();

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {28'd0, an}, {28'd0, 4'b1111});
        check("rst_sseg", {25'd0, sseg}, {25'd0, 7'b1111111});
        check("rst_dp_err_ft", {29'd0, dp, err, frame_tick}, {29'd0, 3'b100});
        reset_n = 1'b1;
        cycle();
        check("first_ones_an", {28'd0, an}, {28'd0, 4'b1110});
        check("first_ones_sseg", {25'd0, sseg}, {25'd0, 7'b1000000});

        // Scan order and frame rate
        load(12'h123);
        run(2 * 4 * DIV);
        ticks = 0;
        for (int i = 0; i < 4 * DIV; i++) begin
            cycle();
            if (frame_tick) ticks++;
        end
        check("ticks_per_frame", ticks, 1);

        // Leading-zero blanking
        blank_en = 1'b1;
        load(12'h009);
        run(4 * DIV + 2);
        load(12'h100);
        run(4 * DIV + 2);
        load(12'h010);
        run(4 * DIV + 2);
        load(12'h000);
        run(4 * DIV + 2);
        blank_en = 1'b0;
        run(4 * DIV);

        // Invalid digit flagging and clearing
        blank_en = 1'b1;
        load(12'h0A5);
        check("err_set", {31'd0, err}, 32'd1);
        run(4 * DIV + 2);
        load(12'h0F0);
        run(4 * DIV + 2);
        load(12'h099);
        check("err_clr", {31'd0, err}, 32'd0);
        blank_en = 1'b0;

        // Capture coinciding with 0->1 advance
        load(12'h000);
        align(0);
        load(12'h099);
        cycle();
        check("simul_an", {28'd0, an}, {28'd0, 4'b1101});
        check("simul_sseg", {25'd0, sseg}, {25'd0, 7'b0010000});

        // bcd changes without strobe are ignored
        bcd = 12'h777;
        run(4 * DIV + 2);
        bcd = 12'h3C4;
        run(4 * DIV);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            bcd       = 12'($urandom);
            bcd_valid = ($urandom_range(0, 7) == 0);
            blank_en  = 1'($urandom_range(0, 1));
            cycle();
        end
        bcd_valid = 1'b0;
        blank_en  = 1'b0;

        // Asynchronous reset in the middle of the tens slot
        load(12'h456);
        align(0);
        cycle();
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_an", {28'd0, an}, {28'd0, 4'b1111});
        check("async_sseg", {25'd0, sseg}, {25'd0, 7'b1111111});
        check("async_dp_err_ft", {29'd0, dp, err, frame_tick}, {29'd0, 3'b100});
        model_reset();
        @(posedge clk);
        #1;
        check("async_hold_an", {28'd0, an}, {28'd0, 4'b1111});
        reset_n = 1'b1;
        cycle();
        check("restart_an", {28'd0, an}, {28'd0, 4'b1110});
        check("restart_sseg", {25'd0, sseg}, {25'd0, 7'b1000000});
        run(4 * DIV + 2);

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
